mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  Registered, parametrised MEM pipeline stage between EX/MEM and WB of the RV core.
//  Passes ALU results through to writeback.
//  Sequences loads/stores to the memory controller with a valid/done handshake.
//  Sign-/zero-extends load data per access size and back-pressures EX/MEM while busy.
//  Supersedes the combinational MEM stage; all outputs are registered.
// PARAMETERS
//  XLEN      32  datapath width; 32 or 64 (64 enables size 2'b11 = doubleword)
//  RADDR_W   5   register-file address width
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        reset, synchronous, active-high
//  rdy         in   1        global enable; 0 freezes all state and outputs
//  in_valid    in   1        EX/MEM presents an instruction
//  in_ready    out  1        stage can accept this cycle (in_valid&in_ready = accept)
//  in_is_mem   in   1        1 = load/store, 0 = ALU passthrough
//  in_op       in   4        {store, unsigned, size[1:0]}; size 0=B 1=H 2=W 3=D
//  in_addr     in   XLEN     effective address (mem ops)
//  in_data     in   XLEN     ALU result (passthrough) or store data (stores)
//  in_rd_addr  in   RADDR_W  destination register
//  in_rd_en    in   1        instruction writes rd
//  mem_req     out  1        memory request, held until mem_done
//  mem_we      out  1        1 = store, 0 = load
//  mem_addr    out  XLEN     request address
//  mem_nbytes  out  4        1/2/4/8
//  mem_wdata   out  XLEN     store data, zero above access size
//  mem_rdata   in   XLEN     load data, valid with mem_done (low bytes significant)
//  mem_done    in   1        one-cycle completion pulse
//  wb_valid    out  1        one-cycle writeback pulse
//  wb_rd_en    out  1        write enable (0 if rd==0 or store)
//  wb_rd_addr  out  RADDR_W  writeback register
//  wb_rd_data  out  XLEN     writeback data
// BEHAVIOUR
//  - Reset: state IDLE; in_ready=1; mem_req=0; mem_we=0; mem_addr=0; mem_nbytes=0.
//    Reset also clears mem_wdata=0, wb_valid=0, wb_rd_en=0, wb_rd_addr=0 and wb_rd_data=0.
//    Reset mid-access drops the access and does not wait for mem_done.
//  - rdy=0: no state change, no capture (mem_done ignored), all outputs hold.
//  - FSM IDLE/BUSY/RESP. in_ready=1 only in IDLE.
//  - IDLE, accept, !in_is_mem: next cycle wb_valid=1 and wb_rd_data=in_data.
//    wb_rd_en=in_rd_en&&(rd!=0); stay IDLE (1-cycle latency, back-to-back).
//  - IDLE, accept, in_is_mem: latch op/addr/rd and go to BUSY.
//    Next cycle mem_req=1 with mem_addr/mem_we/mem_nbytes/mem_wdata stable until done.
//  - BUSY & mem_done: mem_req=0 that cycle's edge; load captures mem_rdata; go to RESP.
//  - RESP: wb_valid=1 for one cycle; load data extended per size.
//    Signed ops sign-extend from bit 8*nbytes-1; unsigned ops zero-extend.
//    Store: wb_valid=1, wb_rd_en=0. Next state IDLE, in_ready=1.
//  - Minimum mem op latency: accept->wb_valid = 3 cycles + memory wait.
//  - size 3 with XLEN=32 behaves as W (nbytes=4).
//  - mem_done outside BUSY is ignored. wb_valid is 0 in every cycle not listed above.
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined:
//   - An access is misaligned for H with addr[0]!=0, W with addr[1:0]!=0, or D with addr[2:0]!=0.
//   - A misaligned access is never issued (mem_req stays 0).
//   - Added outputs: exc_valid (1), exc_store (1), exc_addr (XLEN).
//   - exc_valid pulses in the RESP slot with exc_addr=in_addr; wb_valid=1, wb_rd_en=0.
//  Undefined: no exc_* ports; all addresses are forwarded unchanged to memory.
// TESTING
//  - ALU stream: 3 back-to-back accepts, rd=1,2,3, data 0x11/0x22/0x33.
//    -> wb_valid on 3 consecutive cycles, matching data; in_ready never drops.
//  - LB signed, addr 0x100, mem_rdata=0x000000F0, mem_done 4 cycles after mem_req.
//    -> mem_nbytes=1, wb_rd_data=0xFFFFFFF0, in_ready=0 throughout.
//  - LHU then LH with mem_rdata=0x00008001.
//    -> 0x00008001 then 0xFFFF8001.
//  - SW data 0xDEADBEEF, addr 0x200.
//    -> mem_we=1, mem_wdata=0xDEADBEEF, nbytes=4; wb_valid=1, wb_rd_en=0.
//  - rdy=0 for 3 cycles while BUSY with mem_done pulsed during freeze.
//    -> done ignored, mem_req held, completes on next done after rdy=1.
//  - Load with rd=0 -> wb_rd_en=0. With MEM_MISALIGN_TRAP_EN, LW at 0x102.
//    -> no mem_req, exc_valid=1, exc_addr=0x102.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Registered MEM pipeline stage: ALU passthrough to writeback plus load/store sequencing with a valid/done handshake.
// Optional misaligned-access trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_stage_ctrl #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_is_mem,
    input  logic [3:0]         in_op,
    input  logic [XLEN-1:0]    in_addr,
    input  logic [XLEN-1:0]    in_data,
    input  logic [RADDR_W-1:0] in_rd_addr,
    input  logic               in_rd_en,
    output logic               mem_req,
    output logic               mem_we,
    output logic [XLEN-1:0]    mem_addr,
    output logic [3:0]         mem_nbytes,
    output logic [XLEN-1:0]    mem_wdata,
    input  logic [XLEN-1:0]    mem_rdata,
    input  logic               mem_done,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic               exc_valid,
    output logic               exc_store,
    output logic [XLEN-1:0]    exc_addr,
`endif
    output logic               wb_valid,
    output logic               wb_rd_en,
    output logic [RADDR_W-1:0] wb_rd_addr,
    output logic [XLEN-1:0]    wb_rd_data
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t state, next_state;

    logic               uns_q;
    logic               rd_en_q;
    logic               mis_q;
    logic [RADDR_W-1:0] rd_addr_q;
    logic [XLEN-1:0]    rdata_q;
    logic [3:0]         in_nbytes;
    logic               accept;
    logic               mis_in;

    function automatic logic [3:0] size_to_nbytes(input logic [1:0] size);
        case (size)
            2'd0:    return 4'd1;
            2'd1:    return 4'd2;
            2'd2:    return 4'd4;
            default: return (XLEN == 64) ? 4'd8 : 4'd4;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] byte_mask(input logic [3:0] nbytes);
        logic [XLEN-1:0] m;
        m = '0;
        for (int i = 0; i < XLEN / 8; i++) begin
            if (i < int'(nbytes)) m[8*i +: 8] = 8'hFF;
        end
        return m;
    endfunction

    // Sign bit is the top bit of the accessed bytes; unsigned loads zero-fill instead.
    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] d,
                                                    input logic [3:0] nbytes,
                                                    input logic uns);
        logic            sign;
        logic [XLEN-1:0] m;
        case (nbytes)
            4'd1:    sign = d[7];
            4'd2:    sign = d[15];
            4'd4:    sign = d[31];
            default: sign = d[XLEN-1];
        endcase
        m = byte_mask(nbytes);
        return (d & m) | ((sign && !uns) ? ~m : '0);
    endfunction

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign in_nbytes = size_to_nbytes(in_op[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [2:0] a, input logic [3:0] nbytes);
        case (nbytes)
            4'd2:    return a[0];
            4'd4:    return a[1:0] != 2'b00;
            4'd8:    return a[2:0] != 3'b000;
            default: return 1'b0;
        endcase
    endfunction

    assign mis_in = is_misaligned(in_addr[2:0], in_nbytes);
`else
    assign mis_in = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)      state <= IDLE;
        else if (rdy) state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && in_is_mem) next_state = mis_in ? RESP : BUSY;
            BUSY:    if (mem_done) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The mem_* registers double as the latched operation for the response slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_nbytes <= '0;
            mem_wdata  <= '0;
            wb_valid   <= 1'b0;
            wb_rd_en   <= 1'b0;
            wb_rd_addr <= '0;
            wb_rd_data <= '0;
            uns_q      <= 1'b0;
            rd_en_q    <= 1'b0;
            mis_q      <= 1'b0;
            rd_addr_q  <= '0;
            rdata_q    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            exc_valid  <= 1'b0;
            exc_store  <= 1'b0;
            exc_addr   <= '0;
`endif
        end else if (rdy) begin
            wb_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            exc_valid <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept && !in_is_mem) begin
                        wb_valid   <= 1'b1;
                        wb_rd_en   <= in_rd_en && (in_rd_addr != '0);
                        wb_rd_addr <= in_rd_addr;
                        wb_rd_data <= in_data;
                    end else if (accept) begin
                        mem_req    <= !mis_in;
                        mem_we     <= in_op[3];
                        uns_q      <= in_op[2];
                        mem_nbytes <= in_nbytes;
                        mem_addr   <= in_addr;
                        mem_wdata  <= in_data & byte_mask(in_nbytes);
                        rd_addr_q  <= in_rd_addr;
                        rd_en_q    <= in_rd_en;
                        mis_q      <= mis_in;
                    end
                end
                BUSY: begin
                    if (mem_done) begin
                        mem_req <= 1'b0;
                        if (!mem_we) rdata_q <= mem_rdata;
                    end
                end
                RESP: begin
                    wb_valid   <= 1'b1;
                    wb_rd_addr <= rd_addr_q;
                    wb_rd_en   <= rd_en_q && !mem_we && !mis_q && (rd_addr_q != '0);
                    wb_rd_data <= (mem_we || mis_q) ? '0 : extend_load(rdata_q, mem_nbytes, uns_q);
`ifdef MEM_MISALIGN_TRAP_EN
                    exc_valid  <= mis_q;
                    exc_store  <= mem_we;
                    exc_addr   <= mem_addr;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (XLEN=32); covers the trap path when MEM_MISALIGN_TRAP_EN is defined.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, in_valid, in_ready, in_is_mem, in_rd_en;
    logic [3:0]  in_op;
    logic [31:0] in_addr, in_data;
    logic [4:0]  in_rd_addr;
    logic        mem_req, mem_we, mem_done;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_nbytes;
    logic        wb_valid, wb_rd_en;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_data;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        exc_valid, exc_store;
    logic [31:0] exc_addr;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_mem(in_is_mem),
        .in_op(in_op), .in_addr(in_addr), .in_data(in_data),
        .in_rd_addr(in_rd_addr), .in_rd_en(in_rd_en),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_nbytes(mem_nbytes), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
`ifdef MEM_MISALIGN_TRAP_EN
        .exc_valid(exc_valid), .exc_store(exc_store), .exc_addr(exc_addr),
`endif
        .wb_valid(wb_valid), .wb_rd_en(wb_rd_en),
        .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic is_mem, input logic [3:0] op,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [4:0] rd, input logic rd_en);
        in_valid   = valid;
        in_is_mem  = is_mem;
        in_op      = op;
        in_addr    = addr;
        in_data    = data;
        in_rd_addr = rd;
        in_rd_en   = rd_en;
    endtask

    // Accepts one memory op, checks the request, waits, pulses done, then stops in the writeback cycle.
    task automatic runMemOp(input string tag, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] data, input logic [4:0] rd, input logic rd_en,
                            input int wait_cycles, input logic [31:0] rdata,
                            input logic [3:0] exp_nbytes, input logic [31:0] exp_wdata);
        applyStimulus(1'b1, 1'b1, op, addr, data, rd, rd_en);
        step();
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        checkOutput({tag, ".req"},    mem_req, 1);
        checkOutput({tag, ".ready"},  in_ready, 0);
        checkOutput({tag, ".addr"},   mem_addr, addr);
        checkOutput({tag, ".we"},     mem_we, op[3]);
        checkOutput({tag, ".nbytes"}, mem_nbytes, exp_nbytes);
        checkOutput({tag, ".wdata"},  mem_wdata, exp_wdata);
        repeat (wait_cycles) step();
        checkOutput({tag, ".reqHeld"},   mem_req, 1);
        checkOutput({tag, ".readyBusy"}, in_ready, 0);
        mem_done  = 1'b1;
        mem_rdata = rdata;
        step();
        mem_done  = 1'b0;
        mem_rdata = 32'd0;
        checkOutput({tag, ".reqDrop"}, mem_req, 0);
        checkOutput({tag, ".wbEarly"}, wb_valid, 0);
        step();
        checkOutput({tag, ".wbValid"}, wb_valid, 1);
        checkOutput({tag, ".readyWb"}, in_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        mem_done  = 1'b0;
        mem_rdata = 32'd0;
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        step();
        step();
        rst = 1'b0;
        checkOutput("rst.ready",  in_ready, 1);
        checkOutput("rst.req",    mem_req, 0);
        checkOutput("rst.nbytes", mem_nbytes, 0);
        checkOutput("rst.addr",   mem_addr, 0);
        checkOutput("rst.wb",     wb_valid, 0);
        checkOutput("rst.wbdata", wb_rd_data, 0);

        // ALU stream, three back-to-back accepts
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 32'h11 * i, 5'(i), 1'b1);
            step();
            checkOutput("alu.valid", wb_valid, 1);
            checkOutput("alu.data",  wb_rd_data, 32'h11 * i);
            checkOutput("alu.rd",    wb_rd_addr, i);
            checkOutput("alu.rden",  wb_rd_en, 1);
            checkOutput("alu.ready", in_ready, 1);
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        step();
        checkOutput("alu.idle", wb_valid, 0);

        // LB signed, done 4 cycles after mem_req
        runMemOp("lb", 4'b0000, 32'h100, 32'd0, 5'd5, 1'b1, 4, 32'h0000_00F0, 4'd1, 32'd0);
        checkOutput("lb.data", wb_rd_data, 32'hFFFF_FFF0);
        checkOutput("lb.rden", wb_rd_en, 1);
        checkOutput("lb.rd",   wb_rd_addr, 5);
        step();
        checkOutput("lb.pulse", wb_valid, 0);

        runMemOp("lhu", 4'b0101, 32'h104, 32'd0, 5'd6, 1'b1, 1, 32'h0000_8001, 4'd2, 32'd0);
        checkOutput("lhu.data", wb_rd_data, 32'h0000_8001);
        runMemOp("lh", 4'b0001, 32'h104, 32'd0, 5'd6, 1'b1, 0, 32'h0000_8001, 4'd2, 32'd0);
        checkOutput("lh.data", wb_rd_data, 32'hFFFF_8001);

        runMemOp("sw", 4'b1010, 32'h200, 32'hDEAD_BEEF, 5'd7, 1'b1, 2, 32'd0, 4'd4, 32'hDEAD_BEEF);
        checkOutput("sw.rden", wb_rd_en, 0);
        runMemOp("sb", 4'b1000, 32'h201, 32'hDEAD_BEEF, 5'd7, 1'b0, 0, 32'd0, 4'd1, 32'h0000_00EF);
        checkOutput("sb.rden", wb_rd_en, 0);

        // size 3 on a 32-bit datapath is a word access
        runMemOp("ld32", 4'b0011, 32'h300, 32'd0, 5'd8, 1'b1, 0, 32'h8000_0000, 4'd4, 32'd0);
        checkOutput("ld32.data", wb_rd_data, 32'h8000_0000);

        runMemOp("lwr0", 4'b0010, 32'h308, 32'd0, 5'd0, 1'b1, 0, 32'h1234_5678, 4'd4, 32'd0);
        checkOutput("lwr0.rden", wb_rd_en, 0);

        // Freeze while BUSY with done pulsed during the freeze
        applyStimulus(1'b1, 1'b1, 4'b0010, 32'h400, 32'd0, 5'd9, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        rdy = 1'b0;
        mem_done  = 1'b1;
        mem_rdata = 32'hAAAA_AAAA;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("frz.req",   mem_req, 1);
            checkOutput("frz.ready", in_ready, 0);
        end
        rdy = 1'b1;
        mem_done  = 1'b0;
        mem_rdata = 32'd0;
        step();
        step();
        checkOutput("frz.reqAfter", mem_req, 1);
        checkOutput("frz.noWb",     wb_valid, 0);
        mem_done  = 1'b1;
        mem_rdata = 32'h1234_5678;
        step();
        mem_done  = 1'b0;
        checkOutput("frz.reqDrop", mem_req, 0);
        step();
        checkOutput("frz.wb",   wb_valid, 1);
        checkOutput("frz.data", wb_rd_data, 32'h1234_5678);

        // Stray done while idle
        step();
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        step();
        checkOutput("stray.wb",    wb_valid, 0);
        checkOutput("stray.ready", in_ready, 1);

        // Reset in the middle of an access
        applyStimulus(1'b1, 1'b1, 4'b0010, 32'h500, 32'd0, 5'd3, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        checkOutput("mrst.req1", mem_req, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("mrst.req",   mem_req, 0);
        checkOutput("mrst.ready", in_ready, 1);
        step();
        checkOutput("mrst.wb", wb_valid, 0);

`ifdef MEM_MISALIGN_TRAP_EN
        applyStimulus(1'b1, 1'b1, 4'b0010, 32'h102, 32'd0, 5'd4, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        checkOutput("mis.req", mem_req, 0);
        step();
        checkOutput("mis.req2",  mem_req, 0);
        checkOutput("mis.wb",    wb_valid, 1);
        checkOutput("mis.rden",  wb_rd_en, 0);
        checkOutput("mis.exc",   exc_valid, 1);
        checkOutput("mis.store", exc_store, 0);
        checkOutput("mis.addr",  exc_addr, 32'h102);
        step();
        checkOutput("mis.pulse", exc_valid, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
